// File: rtl/rssb_pkg.sv
// Shared RSSB constants and loader state encoding.
// RSSB_LOADER_CHECKSUM_EN adds the checksum trailer states.
package rssb_pkg;

  localparam int ADDR_PC       = 0;
  localparam int ADDR_ACC      = 1;
  localparam int ADDR_ZERO     = 2;
  localparam int LOAD_BASE_DEF = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_DAT_HI,
    ST_DAT_LO,
    ST_WRITE,
    ST_RUN,
    ST_ERR
`ifdef RSSB_LOADER_CHECKSUM_EN
    ,
    ST_CHK_HI,
    ST_CHK_LO
`endif
  } loader_state_t;

  // States that accept a stream byte
  function automatic logic st_ready(
    loader_state_t s
  );
    logic v;
    v = 1'b0;
    case (s)
      ST_HDR_HI,
      ST_HDR_LO,
      ST_DAT_HI,
      ST_DAT_LO: v = 1'b1;
`ifdef RSSB_LOADER_CHECKSUM_EN
      ST_CHK_HI,
      ST_CHK_LO: v = 1'b1;
`endif
      default:   v = 1'b0;
    endcase
    return v;
  endfunction

  // States whose byte completes a word
  function automatic logic st_lo(
    loader_state_t s
  );
    logic v;
    v = 1'b0;
    case (s)
      ST_HDR_LO,
      ST_DAT_LO: v = 1'b1;
`ifdef RSSB_LOADER_CHECKSUM_EN
      ST_CHK_LO: v = 1'b1;
`endif
      default:   v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rssb_byte_assembler.sv
// Byte handshake and high/low pairing into 16-bit words.
// Ready is driven purely by the loader state.
module rssb_byte_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_en,
  input  logic        i_lo,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        o_fire,
  output logic        o_word_valid,
  output logic [15:0] o_word
);

  logic [7:0] r_hi;

  assign in_ready     = i_en;
  assign o_fire       = in_valid & i_en;
  assign o_word_valid = o_fire & i_lo;
  assign o_word       = {r_hi, in_data};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hi <= 8'h00;
    end else if (o_fire && !i_lo) begin
      r_hi <= in_data;
    end
  end

endmodule

// File: rtl/rssb_loader.sv
// Boot loader: byte stream -> program memory, then CPU release.
// RSSB_LOADER_CHECKSUM_EN appends a 16-bit sum check.
module rssb_loader
  import rssb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = 65536,
  parameter int LOAD_BASE = LOAD_BASE_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  loader_state_t     r_state;
  loader_state_t     w_next;
  loader_state_t     w_end_st;
  logic [15:0]       r_count;
  logic [15:0]       r_index;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_mem_wdata;
  logic              w_en;
  logic              w_lo;
  logic              w_fire;
  logic              w_word_valid;
  logic [15:0]       w_word;
  logic              w_too_big;
  logic              w_zero;
  logic              w_last;
  logic              w_enter_hdr;
`ifdef RSSB_LOADER_CHECKSUM_EN
  logic [15:0]       r_sum;
  logic              w_sum_ok;
`endif

  assign w_en = st_ready(r_state);
  assign w_lo = st_lo(r_state);

  rssb_byte_assembler u_asm (
    .clock        (clock),
    .reset        (reset),
    .i_en         (w_en),
    .i_lo         (w_lo),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .o_fire       (w_fire),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // Bound keeps LOAD_BASE+index inside memory
  assign w_too_big = 32'(w_word) >
                     32'(MEM_DEPTH - LOAD_BASE);
  assign w_zero    = (w_word == 16'h0000);
  assign w_last    = (r_index + 16'd1) == r_count;

`ifdef RSSB_LOADER_CHECKSUM_EN
  assign w_end_st = ST_CHK_HI;
  assign w_sum_ok = (w_word == r_sum);
`else
  assign w_end_st = ST_RUN;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_HDR_HI;
      end
      ST_HDR_HI: begin
        if (w_fire) w_next = ST_HDR_LO;
      end
      ST_HDR_LO: begin
        if (w_word_valid) begin
          if (w_too_big)   w_next = ST_ERR;
          else if (w_zero) w_next = w_end_st;
          else             w_next = ST_DAT_HI;
        end
      end
      ST_DAT_HI: begin
        if (w_fire) w_next = ST_DAT_LO;
      end
      ST_DAT_LO: begin
        if (w_word_valid) w_next = ST_WRITE;
      end
      ST_WRITE: begin
        w_next = w_last ? w_end_st : ST_DAT_HI;
      end
      ST_RUN: begin
        if (start) w_next = ST_HDR_HI;
      end
      ST_ERR: begin
        if (start) w_next = ST_HDR_HI;
      end
`ifdef RSSB_LOADER_CHECKSUM_EN
      ST_CHK_HI: begin
        if (w_fire) w_next = ST_CHK_LO;
      end
      ST_CHK_LO: begin
        if (w_word_valid)
          w_next = w_sum_ok ? ST_RUN : ST_ERR;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_enter_hdr = (w_next == ST_HDR_HI) &&
                       (r_state != ST_HDR_HI);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_count     <= 16'h0000;
      r_index     <= 16'h0000;
      r_mem_addr  <= '0;
      r_mem_wdata <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (w_enter_hdr) begin
        r_index <= 16'h0000;
      end
      if (r_state == ST_HDR_LO && w_word_valid) begin
        r_count <= w_word;
      end
      // Address/data latched here stay stable through WRITE
      if (r_state == ST_DAT_LO && w_word_valid) begin
        r_mem_addr  <= ADDR_W'(LOAD_BASE) +
                       ADDR_W'(r_index);
        r_mem_wdata <= w_word;
      end
      if (r_state == ST_WRITE) begin
        r_index <= r_index + 16'd1;
      end
    end
  end

`ifdef RSSB_LOADER_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sum <= 16'h0000;
    end else if (w_enter_hdr) begin
      r_sum <= 16'h0000;
    end else if (r_state == ST_WRITE) begin
      r_sum <= r_sum + r_mem_wdata;
    end
  end
`endif

  assign mem_we    = (r_state == ST_WRITE);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_reset = (r_state != ST_RUN);
  assign busy      = w_en | mem_we;
  assign done      = (r_state == ST_RUN);
  assign error     = (r_state == ST_ERR);

endmodule
